neuron_bus_arbiter: RTL and testbench
=====================================

# neuron_bus_arbiter

Round-robin arbiter and capture stage for the shared 21-bit neuron output bus. It is the control stage directly upstream of the `triStateBuffer` bank: it produces each buffer's per-bit `control` mask, so at most one source drives the bus at a time. It samples the resolved bus value into a register and hands it downstream over a valid/ready handshake.

## Interface
Parameters:
- `N_SRC`, default 4: number of tri-state sources on the bus (2–16).
- `WIDTH`, default 21: bus width; must match the buffer width.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `req`  in  N_SRC: level request per source; held by the source until its `ack`.
- `bus_in`  in  WIDTH: resolved value of the shared tri-state bus.
- `oe`  out  N_SRC*WIDTH: per-source control masks. Slice `[i*WIDTH +: WIDTH]` drives buffer `i`. Each slice is all-ones or all-zeros.
- `grant`  out  N_SRC: one-hot owner of the current transaction; zero when idle.
- `ack`  out  N_SRC: one-cycle pulse to the source whose word was consumed.
- `out_data`  out  WIDTH: captured bus word.
- `out_src`  out  $clog2(N_SRC): index of the source that produced `out_data`.
- `out_valid`  out  1: `out_data`/`out_src` are valid.
- `out_ready`  in  1: downstream accepts the word.

## Operation
- FSM states: IDLE, DRIVE, HOLD, GAP (GAP exists only with the macro).
- **IDLE**
  - Eligible set = `req & ~ack`.
  - If the set is non-zero, pick the first set bit at or above `ptr`, wrapping modulo N_SRC.
  - Register it into `grant` and go to DRIVE.
- **DRIVE** (exactly 1 cycle)
  - The `oe` slice of the granted source is all-ones; all other slices are zero.
  - At the closing edge: `out_data <= bus_in`, `out_src <= index`, `out_valid <= 1`, go to HOLD.
- **HOLD**
  - `oe` is all-zero; `grant` is held.
  - `out_valid` stays high and `out_data` stays stable until `out_valid && out_ready`.
  - On that handshake edge:
    - `ack[index] <= 1` for one cycle.
    - `ptr <= (index+1) mod N_SRC`.
    - `grant <= 0`, `out_valid <= 0`.
    - Go to GAP if the macro is defined, else IDLE.
- **GAP**: 1 cycle with all `oe` zero, then IDLE.
- A source dropping `req` during DRIVE or HOLD does not abort the transaction. The captured word is delivered and acked.
- `req` of non-granted sources has no effect outside IDLE.
- Invariant: `oe` is non-zero in DRIVE only, for exactly one slice.
- **Reset**
  - All outputs go to 0: `oe`, `grant`, `ack`, `out_data`, `out_src`, `out_valid`.
  - `ptr` = 0, state = IDLE.
- Reset asserted mid-transaction: at the next edge every output clears and the pending word is discarded without an `ack`.

## Timing
- `req` high before edge 0 (in IDLE) → `grant`/`oe` high in cycle 1 → `out_valid` high in cycle 2.
- With `out_ready` held high, the handshake occurs at the end of cycle 2 and `ack` is high in cycle 3.
- Without the macro, cycle 3 is IDLE. Back-to-back throughput is one word per 3 cycles, and the next DRIVE is cycle 4.
- With the macro, cycle 3 is GAP. The next DRIVE is cycle 5, one word per 4 cycles.
- Backpressure: each cycle of `out_ready` low extends HOLD by one cycle. `out_data` must not change during the stall.
- `ack` and IDLE selection coincide; the `~ack` mask prevents immediate re-grant of the just-served source on its stale `req`.

## Configuration
- Macro `NEURON_BUS_TURNAROUND_EN`.
- Defined: GAP state is compiled in, giving one idle bus cycle after every transaction before the next driver enables. This covers targets with slow tri-state release.
- Undefined: no GAP state; HOLD returns directly to IDLE.

## Structure
- Package `neuron_bus_pkg` holds:
  - the FSM state enum `arb_state_t`;
  - `BUS_WIDTH = 21`;
  - the `$clog2`-based index width helper.
- Sub-module `rr_pick`: purely combinational round-robin selector. Inputs are `eligible` and `ptr`; outputs are one-hot `pick`, `pick_idx` and `any`. The arbiter registers its outputs.

## Test plan
- Single request: N_SRC=4, `req`=4'b0100, `bus_in`=21'd64 during DRIVE, `out_ready`=1. Expect:
  - `oe[2*21 +: 21]` = all-ones for exactly 1 cycle;
  - `out_data`=64, `out_src`=2;
  - `ack`=4'b0100 one cycle later.
- Fairness: `req`=4'b1111 held, each source re-asserting after its `ack`. Expect the grant order 0,1,2,3,0 with no source granted twice in a row.
- Backpressure: `out_ready` low for 5 cycles after `out_valid`. Expect `out_data` (value 32) stable for 6 cycles, `oe` zero throughout, and `ack` only after `out_ready` rises.
- Request drop: `req[1]` falls during DRIVE. Expect the word still delivered with `out_src`=1 and `ack[1]` pulsed.
- Reset mid-HOLD: `rst` high for 1 cycle while `out_valid`=1. Expect all outputs 0 at the next edge, no `ack`, and `ptr`=0 (next grant to the lowest requester).
- Macro build: `req`=4'b0011. Expect exactly one all-zero-`oe` GAP cycle between the source 0 and source 1 DRIVE cycles, and no cycle where two `oe` slices are non-zero.

Source files
------------

// File: rtl/neuron_bus_pkg.sv
// rtl/neuron_bus_pkg.sv - shared types and helpers for the neuron bus arbiter
// GAP state present only when NEURON_BUS_TURNAROUND_EN is defined.
package neuron_bus_pkg;

    localparam int BUS_WIDTH = 21;

`ifdef NEURON_BUS_TURNAROUND_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } arb_state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } arb_state_t;
`endif

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/neuron_bus_arbiter_rr_pick.sv
// rtl/neuron_bus_arbiter_rr_pick.sv - combinational round-robin selector
// Picks the first eligible source at or above ptr, wrapping modulo N.
module rr_pick
    import neuron_bus_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] pick_idx,
    output logic          any
);

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        any      = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (!any && eligible[j]) begin
                any      = 1'b1;
                pick[j]  = 1'b1;
                pick_idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/neuron_bus_arbiter.sv
// rtl/neuron_bus_arbiter.sv - round-robin tri-state bus arbiter with capture stage
// Optional turnaround cycle: NEURON_BUS_TURNAROUND_EN.
module neuron_bus_arbiter
    import neuron_bus_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int WIDTH = BUS_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_SRC-1:0]            req,
    input  logic [WIDTH-1:0]            bus_in,
    output logic [N_SRC*WIDTH-1:0]      oe,
    output logic [N_SRC-1:0]            grant,
    output logic [N_SRC-1:0]            ack,
    output logic [WIDTH-1:0]            out_data,
    output logic [idx_width(N_SRC)-1:0] out_src,
    output logic                        out_valid,
    input  logic                        out_ready
);

    localparam int IW = idx_width(N_SRC);

    arb_state_t           state;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        idx;
    logic [N_SRC-1:0]     pick;
    logic [IW-1:0]        pick_idx;
    logic                 any;
    logic [N_SRC*WIDTH-1:0] oe_next;

    // The just-acked source still shows its stale req this cycle; mask it out.
    rr_pick #(.N(N_SRC), .IW(IW)) u_pick (
        .eligible (req & ~ack),
        .ptr      (ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .any      (any)
    );

    always_comb begin
        oe_next = '0;
        for (int i = 0; i < N_SRC; i++) begin
            oe_next[i*WIDTH +: WIDTH] = {WIDTH{pick[i]}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            idx       <= '0;
            oe        <= '0;
            grant     <= '0;
            ack       <= '0;
            out_data  <= '0;
            out_src   <= '0;
            out_valid <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (any) begin
                        grant <= pick;
                        idx   <= pick_idx;
                        oe    <= oe_next;
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    oe        <= '0;
                    out_data  <= bus_in;
                    out_src   <= idx;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        ack       <= grant;
                        ptr       <= (idx == IW'(N_SRC - 1)) ? '0 : idx + IW'(1);
                        grant     <= '0;
                        out_valid <= 1'b0;
`ifdef NEURON_BUS_TURNAROUND_EN
                        state     <= GAP;
`else
                        state     <= IDLE;
`endif
                    end
                end
`ifdef NEURON_BUS_TURNAROUND_EN
                GAP: begin
                    state <= IDLE;
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_bus_arbiter.sv
// tb/tb_neuron_bus_arbiter.sv - self-checking bench for neuron_bus_arbiter
// Transaction-level reference model; covers both NEURON_BUS_TURNAROUND_EN builds.
module tb_neuron_bus_arbiter;

    localparam int N = 4;
    localparam int W = 21;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [W-1:0]     bus_in;
    logic [N*W-1:0]   oe;
    logic [N-1:0]     grant;
    logic [N-1:0]     ack;
    logic [W-1:0]     out_data;
    logic [1:0]       out_src;
    logic             out_valid;
    logic             out_ready;

    int checks = 0;
    int errors = 0;

    // Reference model: rotation pointer and the source acked in the current cycle
    int           m_ptr = 0;
    logic [N-1:0] m_ack = '0;

    neuron_bus_arbiter #(.N_SRC(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .bus_in    (bus_in),
        .oe        (oe),
        .grant     (grant),
        .ack       (ack),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner is the eligible source with the smallest forward distance from the pointer
    function automatic int model_pick(input logic [N-1:0] elig);
        int best, bestd;
        best  = -1;
        bestd = N;
        for (int j = 0; j < N; j++) begin
            if (elig[j] && ((j - m_ptr + N) % N) < bestd) begin
                bestd = (j - m_ptr + N) % N;
                best  = j;
            end
        end
        return best;
    endfunction

    function automatic logic [127:0] oe_mask(input int w);
        logic [N*W-1:0] m;
        m = '0;
        m[w*W +: W] = '1;
        return 128'(m);
    endfunction

    function automatic logic [127:0] onehot(input int w);
        return 128'(1) << w;
    endfunction

    // Entered in a cycle where the DUT is in IDLE; returns after the ack (and gap) cycle.
    task automatic do_txn(input logic [N-1:0] new_req, input logic [W-1:0] word,
                          input int stall, input bit drop, input bit keep);
        int w;
        req = new_req;
        w = model_pick(req & ~m_ack);
        out_ready = (stall == 0);
        bus_in = W'($urandom);
        tick();
        chk("grant_drive", grant, onehot(w));
        chk("oe_drive", oe, oe_mask(w));
        chk("valid_drive", out_valid, 0);
        bus_in = word;
        if (drop) req[w] = 1'b0;
        tick();
        bus_in = W'($urandom);
        chk("oe_hold", oe, 0);
        chk("valid_hold", out_valid, 1);
        chk("data_hold", out_data, word);
        chk("src_hold", out_src, w);
        chk("grant_hold", grant, onehot(w));
        for (int s = 1; s <= stall; s++) begin
            tick();
            bus_in = W'($urandom);
            if (s == stall) out_ready = 1'b1;
            chk("data_stall", out_data, word);
            chk("oe_stall", oe, 0);
            chk("ack_stall", ack, 0);
            chk("valid_stall", out_valid, 1);
        end
        tick();
        chk("ack_pulse", ack, onehot(w));
        chk("valid_after", out_valid, 0);
        chk("grant_after", grant, 0);
        chk("oe_after", oe, 0);
        m_ack = N'(onehot(w));
        m_ptr = (w + 1) % N;
        if (!keep) req[w] = 1'b0;
`ifdef NEURON_BUS_TURNAROUND_EN
        tick();
        chk("oe_gap", oe, 0);
        chk("grant_gap", grant, 0);
        chk("ack_gap", ack, 0);
        m_ack = '0;
`endif
    endtask

    initial begin
        logic [N-1:0] nr;
        int b;
        rst = 1'b1;
        req = '0;
        bus_in = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_oe", oe, 0);
        chk("rst_grant", grant, 0);
        chk("rst_ack", ack, 0);
        chk("rst_data", out_data, 0);
        chk("rst_src", out_src, 0);
        chk("rst_valid", out_valid, 0);
        rst = 1'b0;
        tick();
        tick();
        chk("idle_grant", grant, 0);
        chk("idle_oe", oe, 0);

        // Single request from source 2
        do_txn(4'b0100, 21'd64, 0, 1'b0, 1'b0);

        // Reset while HOLD: word discarded, no ack, pointer back to 0
        req = 4'b1000;
        out_ready = 1'b0;
        b = model_pick(req & ~m_ack);
        tick();
        chk("rh_grant", grant, onehot(b));
        bus_in = 21'h1abcd;
        tick();
        chk("rh_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = '0;
        out_ready = 1'b1;
        chk("rh_oe", oe, 0);
        chk("rh_grant0", grant, 0);
        chk("rh_ack", ack, 0);
        chk("rh_data", out_data, 0);
        chk("rh_src", out_src, 0);
        chk("rh_valid0", out_valid, 0);
        m_ptr = 0;
        m_ack = '0;
        tick();
        chk("rh_noack", ack, 0);

        // Fairness with every source requesting continuously: 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            do_txn(4'b1111, W'($urandom), 0, 1'b0, 1'b1);
        end

        // Source 1 drops req during DRIVE
        do_txn(4'b0010, W'($urandom), 0, 1'b1, 1'b0);

        // Backpressure: ready low for five cycles
        do_txn(4'b0001, 21'd32, 5, 1'b0, 1'b0);

        // Randomized traffic; pending requests are held until acked
        for (int i = 0; i < 25; i++) begin
            nr = req | N'($urandom);
            if ((nr & ~m_ack) == '0) begin
                b = $urandom_range(0, N - 1);
                while (m_ack[b]) b = (b + 1) % N;
                nr[b] = 1'b1;
            end
            do_txn(nr, W'($urandom), $urandom_range(0, 3), 1'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
